// File: rtl/nanci_sort_seq.sv
// nanci_sort_seq: global schedule sequencer for the Nanci PE mesh shearsort.
// Runs IDLE -> LOAD -> SORT (P alternating row/column phases) -> DONE.
// Optional feature macro: NANCI_SEQ_PAUSE_EN adds i_pause to stall LOAD/SORT.
// All outputs come straight from flops; next values are decoded from next state.
module nanci_sort_seq #(
    parameter int unsigned SQRT_N      = 4,
    parameter int unsigned SORT_CYCLES = 4,
    parameter int unsigned NUM_ROUNDS  = 2,
    parameter int unsigned LOAD_CYCLES = 2,
    localparam int unsigned P  = 2 * NUM_ROUNDS + 1,
    localparam int unsigned PW = (P > 1) ? $clog2(P) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_abort,
`ifdef NANCI_SEQ_PAUSE_EN
    input  logic          i_pause,
`endif
    output logic          o_busy,
    output logic          o_load,
    output logic          o_step_en,
    output logic [1:0]    o_dir,
    output logic          o_parity,
    output logic [PW-1:0] o_phase,
    output logic          o_done
);

    localparam int unsigned SW        = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
    localparam int unsigned LW        = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int unsigned SORT_LAST = (SORT_CYCLES > 0) ? SORT_CYCLES - 1 : 0;
    localparam int unsigned LOAD_LAST = (LOAD_CYCLES > 0) ? LOAD_CYCLES - 1 : 0;
    localparam int unsigned PH_LAST   = P - 1;

    // Mesh side length only documents the target mesh; it sizes nothing here.
    if (SQRT_N < 1) begin : g_sqrt_n_unused
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [LW-1:0]   load_cnt_q, load_cnt_d;
    logic            stall;

    logic            o_busy_q, o_busy_d;
    logic            o_load_q, o_load_d;
    logic            o_step_en_q, o_step_en_d;
    logic [1:0]      o_dir_q, o_dir_d;
    logic            o_parity_q, o_parity_d;
    logic [PW-1:0]   o_phase_q, o_phase_d;
    logic            o_done_q, o_done_d;

    // Pause only stalls the active windows, and abort always overrides it.
    always_comb begin
        stall = 1'b0;
`ifdef NANCI_SEQ_PAUSE_EN
        stall = i_pause && !i_abort && (state_q == S_LOAD || state_q == S_SORT);
`endif
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        phase_d    = phase_q;
        load_cnt_d = load_cnt_q;
        case (state_q)
            S_IDLE: begin
                step_d     = '0;
                phase_d    = '0;
                load_cnt_d = '0;
                if (i_start && !i_abort)
                    state_d = (LOAD_CYCLES == 0) ? S_SORT : S_LOAD;
            end
            S_LOAD: begin
                if (i_abort) begin
                    state_d    = S_IDLE;
                    load_cnt_d = '0;
                end else if (!stall) begin
                    if (load_cnt_q == LW'(LOAD_LAST)) begin
                        state_d    = S_SORT;
                        load_cnt_d = '0;
                        step_d     = '0;
                        phase_d    = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            S_SORT: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    phase_d = '0;
                end else if (!stall) begin
                    if (step_q == SW'(SORT_LAST)) begin
                        step_d = '0;
                        if (phase_q == PW'(PH_LAST)) begin
                            state_d = S_DONE;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
                phase_d = '0;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state.
    always_comb begin
        o_busy_d    = (state_d != S_IDLE);
        o_load_d    = (state_d == S_LOAD) && !stall;
        o_step_en_d = (state_d == S_SORT) && !stall;
        o_dir_d     = '0;
        o_parity_d  = 1'b0;
        o_phase_d   = '0;
        o_done_d    = (state_d == S_DONE);
        if (state_d == S_SORT) begin
            o_dir_d    = phase_d[0] ? 2'b10 : 2'b01;
            o_parity_d = step_d[0];
            o_phase_d  = phase_d;
        end
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            phase_q     <= '0;
            load_cnt_q  <= '0;
            o_busy_q    <= 1'b0;
            o_load_q    <= 1'b0;
            o_step_en_q <= 1'b0;
            o_dir_q     <= '0;
            o_parity_q  <= 1'b0;
            o_phase_q   <= '0;
            o_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            phase_q     <= phase_d;
            load_cnt_q  <= load_cnt_d;
            o_busy_q    <= o_busy_d;
            o_load_q    <= o_load_d;
            o_step_en_q <= o_step_en_d;
            o_dir_q     <= o_dir_d;
            o_parity_q  <= o_parity_d;
            o_phase_q   <= o_phase_d;
            o_done_q    <= o_done_d;
        end
    end

    assign o_busy    = o_busy_q;
    assign o_load    = o_load_q;
    assign o_step_en = o_step_en_q;
    assign o_dir     = o_dir_q;
    assign o_parity  = o_parity_q;
    assign o_phase   = o_phase_q;
    assign o_done    = o_done_q;

endmodule

// File: tb/tb_nanci_sort_seq.sv
// Testbench for nanci_sort_seq at default parameters (P=5, SORT_CYCLES=4, LOAD_CYCLES=2).
// Expected output vectors come from a cycle-count model of the schedule, queued
// when each edge's stimulus is applied and popped when the DUT outputs are sampled.
module tb_nanci_sort_seq;

    localparam int LC  = 2;
    localparam int SC  = 4;
    localparam int P   = 5;
    localparam int TOT = LC + P * SC;
`ifdef NANCI_SEQ_PAUSE_EN
    localparam bit PAUSE_BUILD = 1'b1;
`else
    localparam bit PAUSE_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic       i_pause = 1'b0;
    logic       o_busy, o_load, o_step_en, o_parity, o_done;
    logic [1:0] o_dir;
    logic [2:0] o_phase;

    nanci_sort_seq #(
        .SQRT_N(4), .SORT_CYCLES(SC), .NUM_ROUNDS(2), .LOAD_CYCLES(LC)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
`ifdef NANCI_SEQ_PAUSE_EN
        .i_pause(i_pause),
`endif
        .o_busy(o_busy), .o_load(o_load), .o_step_en(o_step_en), .o_dir(o_dir),
        .o_parity(o_parity), .o_phase(o_phase), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int start_edge = 0;
    int done_edge = 0;
    int load_cnt = 0;
    int step_cnt = 0;
    int done_cnt = 0;

    // Model: cycles elapsed since the accepted start edge, frozen while paused.
    bit m_active = 1'b0;
    bit m_paused = 1'b0;
    int m_e = 0;
    logic [9:0] sb_q[$];

    // Vector layout: {busy, load, step_en, dir[1:0], parity, phase[2:0], done}
    function automatic logic [9:0] model_out();
        logic [9:0] v;
        int k;
        int ph;
        v = '0;
        if (m_active) begin
            v[9] = 1'b1;
            if (m_e < LC) begin
                v[8] = !m_paused;
            end else if (m_e < TOT) begin
                k  = m_e - LC;
                ph = k / SC;
                v[7]   = !m_paused;
                v[6:5] = (ph % 2 == 1) ? 2'b10 : 2'b01;
                v[4]   = ((k % SC) % 2 == 1);
                v[3:1] = 3'(ph);
            end else begin
                v[0] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic model_edge(input logic s, input logic a, input logic p);
        if (!m_active) begin
            m_paused = 1'b0;
            if (s && !a) begin
                m_active   = 1'b1;
                m_e        = 0;
                start_edge = edge_n;
            end
        end else if (a) begin
            m_active = 1'b0;
            m_paused = 1'b0;
        end else if (m_e == TOT) begin
            m_active = 1'b0;
        end else if (p && PAUSE_BUILD) begin
            m_paused = 1'b1;
        end else begin
            m_paused = 1'b0;
            m_e++;
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic a, input logic p);
        logic [9:0] exp;
        logic [9:0] obs;
        @(negedge clk);
        i_start = s;
        i_abort = a;
        i_pause = p;
        @(posedge clk);
        edge_n++;
        model_edge(s, a, p);
        sb_q.push_back(model_out());
        #1;
        exp = sb_q.pop_front();
        obs = {o_busy, o_load, o_step_en, o_dir, o_parity, o_phase, o_done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL outputs edge %0d: observed %h expected %h", edge_n, obs, exp);
        end
        if (o_load === 1'b1) load_cnt++;
        if (o_step_en === 1'b1) step_cnt++;
        if (o_done === 1'b1) begin
            done_cnt++;
            done_edge = edge_n;
        end
    endtask

    task automatic clear_stats();
        load_cnt = 0;
        step_cnt = 0;
        done_cnt = 0;
        done_edge = -1;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #2;
        check_int("reset_outputs", int'({o_busy, o_load, o_step_en, o_dir, o_parity, o_phase, o_done}), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        // Full run from a single start pulse
        clear_stats();
        cyc(1'b1, 1'b0, 1'b0);
        repeat (25) cyc(1'b0, 1'b0, 1'b0);
        check_int("run1_load_cycles", load_cnt, 2);
        check_int("run1_step_cycles", step_cnt, 20);
        check_int("run1_done_count", done_cnt, 1);
        check_int("run1_done_latency", done_edge - start_edge, 22);

        // Abort while step 7 is showing, then a clean full run
        clear_stats();
        cyc(1'b1, 1'b0, 1'b0);
        repeat (9) cyc(1'b0, 1'b0, 1'b0);
        check_int("pre_abort_phase", int'(o_phase), 1);
        check_int("pre_abort_parity", int'(o_parity), 1);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        check_int("abort_no_done", done_cnt, 0);
        clear_stats();
        cyc(1'b1, 1'b0, 1'b0);
        repeat (24) cyc(1'b0, 1'b0, 1'b0);
        check_int("rerun_step_cycles", step_cnt, 20);
        check_int("rerun_done_latency", done_edge - start_edge, 22);

        // Asynchronous reset mid-SORT
        cyc(1'b1, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_int("async_reset_outputs", int'({o_busy, o_load, o_step_en, o_dir, o_parity, o_phase, o_done}), 0);
        m_active = 1'b0;
        m_paused = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        // Start and abort on the same edge stays in IDLE
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // Start held high: one done pulse, DONE cycle ignores start, restart from IDLE
        clear_stats();
        repeat (24) cyc(1'b1, 1'b0, 1'b0);
        check_int("held_done_count", done_cnt, 1);
        check_int("held_idle_after_done", int'(o_busy), 0);
        cyc(1'b1, 1'b0, 1'b0);
        check_int("held_restart_load", int'(o_load), 1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

`ifdef NANCI_SEQ_PAUSE_EN
        // Pause three cycles while step 5 is showing
        clear_stats();
        cyc(1'b1, 1'b0, 1'b0);
        repeat (7) cyc(1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        repeat (18) cyc(1'b0, 1'b0, 1'b0);
        check_int("pause_step_cycles", step_cnt, 20);
        check_int("pause_done_latency", done_edge - start_edge, 25);
`endif

        // Pause input has no effect in IDLE
        repeat (2) cyc(1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
